// File: rtl/poly_operand_driver.sv
// Initiator for the polynomial evaluator's serial Go/DataIn load:
// shifts out A, B, C, X, then waits for ResultValid or a timeout.
module poly_operand_driver #(
   parameter int W       = 8,
   parameter int GO_HIGH = 2,
   parameter int GO_LOW  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic [W-1:0] op_c,
   input  logic [W-1:0] op_x,
   output logic         go,
   output logic [W-1:0] data_out,
   input  logic [W-1:0] dut_result,
   input  logic         dut_result_valid,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         timeout
);

   localparam int MAXC = (TIMEOUT > GO_HIGH)
                       ? ((TIMEOUT > GO_LOW) ? TIMEOUT : GO_LOW)
                       : ((GO_HIGH > GO_LOW) ? GO_HIGH : GO_LOW);
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] HI_LAST = CW'(GO_HIGH - 1);
   localparam logic [CW-1:0] LO_LAST = CW'(GO_LOW - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_GO_HI,
      S_GO_LO,
      S_WAIT_RES,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [W-1:0]  sa_q, sb_q, sc_q, sx_q;
   logic [1:0]    idx_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  result_q;
   logic          timeout_q;

   logic          go_q, busy_q, done_q;
   logic [W-1:0]  dout_q;
   logic          go_d, busy_d, done_d;
   logic [W-1:0]  dout_d;
   logic [W-1:0]  cur_op;

   always_comb begin
      cur_op = sa_q;
      unique case (idx_q)
         2'd0: cur_op = sa_q;
         2'd1: cur_op = sb_q;
         2'd2: cur_op = sc_q;
         2'd3: cur_op = sx_q;
         default: cur_op = sa_q;
      endcase
   end

   // Outputs are a registered decode of the current state, so nothing
   // on an input pin can reach an output within the same cycle.
   always_comb begin
      go_d   = (state_q == S_GO_HI);
      busy_d = (state_q != S_IDLE);
      done_d = (state_q == S_DONE);
      dout_d = '0;
      if (state_q == S_SETUP || state_q == S_GO_HI ||
          state_q == S_GO_LO) begin
         dout_d = cur_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         sa_q      <= '0;
         sb_q      <= '0;
         sc_q      <= '0;
         sx_q      <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         timeout_q <= 1'b0;
         go_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dout_q    <= '0;
      end else begin
         go_q   <= go_d;
         busy_q <= busy_d;
         done_q <= done_d;
         dout_q <= dout_d;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  sa_q      <= op_a;
                  sb_q      <= op_b;
                  sc_q      <= op_c;
                  sx_q      <= op_x;
                  idx_q     <= 2'd0;
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
                  state_q   <= S_SETUP;
               end
            end
            S_SETUP: begin
               cnt_q   <= '0;
               state_q <= S_GO_HI;
            end
            S_GO_HI: begin
               if (cnt_q == HI_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_GO_LO;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_GO_LO: begin
               if (cnt_q == LO_LAST) begin
                  cnt_q <= '0;
                  if (idx_q == 2'd3) begin
                     state_q <= S_WAIT_RES;
                  end else begin
                     idx_q   <= idx_q + 2'd1;
                     state_q <= S_SETUP;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_WAIT_RES: begin
               if (dut_result_valid) begin
                  result_q <= dut_result;
                  state_q  <= S_DONE;
               end else if (cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign go       = go_q;
   assign data_out = dout_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_poly_operand_driver.sv
// Scoreboard bench for poly_operand_driver against a behavioural
// A*x^2+B*x+C evaluator (GO_HIGH=3, GO_LOW=1, TIMEOUT=8, so P=5).
module tb_poly_operand_driver;

   logic       clk, reset, start;
   logic [7:0] op_a, op_b, op_c, op_x;
   logic       go, busy, done, timeout;
   logic [7:0] data_out, result, dut_result;
   logic       dut_result_valid;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int valid_cyc = 0;
   logic ev_en = 1'b1;

   logic [7:0] exp_ops[$];
   logic [8:0] exp_res[$];

   poly_operand_driver #(
      .W(8), .GO_HIGH(3), .GO_LOW(1), .TIMEOUT(8)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op_a(op_a),
      .op_b(op_b),
      .op_c(op_c),
      .op_x(op_x),
      .go(go),
      .data_out(data_out),
      .dut_result(dut_result),
      .dut_result_valid(dut_result_valid),
      .busy(busy),
      .done(done),
      .result(result),
      .timeout(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int want);
      compared++;
      if (act != want) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, want);
      end
   endtask

   // Returns at negedge+1 of the cycle whose edge count is k.
   task automatic wait_cyc(input int k);
      while (cyc < k || clk == 1'b1) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int n);
      int k;
      k = 0;
      while (done_cnt < n && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (done_cnt < n) begin
         compared++;
         mismatched++;
         $display("FAIL done wait: got %0d dones, required %0d", done_cnt, n);
      end
   endtask

   task automatic push_txn(input logic [7:0] a, b, c, x,
                           input logic to, input logic [7:0] r);
      exp_ops.push_back(a);
      exp_ops.push_back(b);
      exp_ops.push_back(c);
      exp_ops.push_back(x);
      exp_res.push_back({to, r});
   endtask

   task automatic run_start(input logic [7:0] a, b, c, x, output int t0);
      @(posedge clk);
      #1;
      op_a = a; op_b = b; op_c = c; op_x = x;
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   // Behavioural evaluator: latches one operand per go rise, answers
   // five cycles after X, drops a stale valid when the next A arrives.
   initial begin
      logic       pg;
      logic [7:0] pd;
      logic [7:0] o[4];
      int         n, lat;
      pg = 1'b0; pd = '0; n = 0; lat = -1;
      dut_result = '0;
      dut_result_valid = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            n = 0; lat = -1; pg = 1'b0;
            dut_result_valid = 1'b0;
         end else begin
            if (lat > 0) begin
               lat--;
               if (lat == 0 && ev_en) begin
                  dut_result = o[0] * o[3] * o[3] + o[1] * o[3] + o[2];
                  dut_result_valid = 1'b1;
                  valid_cyc = cyc;
               end
            end
            if (go && !pg) begin
               check("setup stable", data_out, pd);
               if (exp_ops.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL operand: unexpected go, data %0d", data_out);
               end else begin
                  check("operand", data_out, exp_ops.pop_front());
               end
               if (n == 0) dut_result_valid = 1'b0;
               o[n] = data_out;
               n++;
               if (n == 4) begin
                  n = 0;
                  lat = 5;
               end
            end
            pg = go;
         end
         pd = data_out;
      end
   end

   // Monitor: go shape, data hold, and result scoreboard on done.
   initial begin
      int         len;
      logic       pg;
      logic [7:0] held;
      logic [8:0] e;
      len = 0; pg = 1'b0; held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            len = 0;
            pg = 1'b0;
         end else begin
            if (go) begin
               if (!pg) held = data_out;
               else check("data hold", data_out, held);
               len++;
            end else if (pg) begin
               check("go width", len, 3);
               check("data at go fall", data_out, held);
               len = 0;
            end
            pg = go;
            if (done) begin
               done_cnt++;
               last_done_cyc = cyc;
               if (exp_res.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL result: unexpected done, result %0d", result);
               end else begin
                  e = exp_res.pop_front();
                  check("result", result, e[7:0]);
                  check("timeout flag", timeout, e[8]);
               end
            end
         end
      end
   end

   initial begin
      int t0, d, dc;
      reset = 1'b1;
      start = 1'b0;
      op_a = '0; op_b = '0; op_c = '0; op_x = '0;
      wait_cyc(3);
      check("rst go", go, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst timeout", timeout, 0);
      check("rst data_out", data_out, 0);
      check("rst result", result, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Nominal: 2*25 + 3*5 + 4 = 69
      push_txn(8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 8'd69);
      run_start(8'd2, 8'd3, 8'd4, 8'd5, t0);
      wait_cyc(t0);
      check("busy at accept", busy, 0);
      wait_cyc(t0 + 1);
      check("busy rise", busy, 1);
      check("go before rise", go, 0);
      wait_cyc(t0 + 2);
      check("first go rise", go, 1);
      wait_cyc(t0 + 20);
      check("X still driven", data_out, 5);
      wait_cyc(t0 + 21);
      check("wait_res data_out", data_out, 0);
      wait_done(1);
      check("done latency", last_done_cyc, valid_cyc + 2);
      d = last_done_cyc;
      check("busy with done", busy, 1);
      wait_cyc(d + 1);
      check("done one cycle", done, 0);
      check("busy fall", busy, 0);

      // Timeout: 4P + TIMEOUT + 1 output register = 29
      ev_en = 1'b0;
      push_txn(8'd7, 8'd7, 8'd7, 8'd7, 1'b1, 8'd69);
      run_start(8'd7, 8'd7, 8'd7, 8'd7, t0);
      wait_done(2);
      check("timeout latency", last_done_cyc - t0, 29);
      ev_en = 1'b1;
      check("timeout sticky", timeout, 1);

      // Width wrap: 1*256 = 0 mod 256; start also clears timeout
      push_txn(8'd1, 8'd0, 8'd0, 8'd16, 1'b0, 8'd0);
      run_start(8'd1, 8'd0, 8'd0, 8'd16, t0);
      wait_cyc(t0);
      check("timeout clear", timeout, 0);
      wait_done(3);

      // Busy start ignored (1*16+2*4+3 = 27), then held start (2*9+1 = 19)
      push_txn(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 8'd27);
      run_start(8'd1, 8'd2, 8'd3, 8'd4, t0);
      wait_cyc(t0 + 3);
      @(posedge clk);
      #1;
      op_a = 8'd9; op_b = 8'd9; op_c = 8'd9; op_x = 8'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      op_a = 8'd2; op_b = 8'd0; op_c = 8'd1; op_x = 8'd3;
      push_txn(8'd2, 8'd0, 8'd1, 8'd3, 1'b0, 8'd19);
      wait_done(4);
      d = last_done_cyc;
      wait_cyc(d + 1);
      check("idle gap busy", busy, 0);
      check("idle gap go", go, 0);
      start = 1'b0;
      wait_cyc(d + 2);
      check("b2b busy", busy, 1);
      wait_cyc(d + 3);
      check("b2b go rise", go, 1);
      wait_done(5);

      // Reset during GO_HI of operand C
      exp_ops.push_back(8'd3);
      exp_ops.push_back(8'd1);
      exp_ops.push_back(8'd4);
      run_start(8'd3, 8'd1, 8'd4, 8'd1, t0);
      dc = done_cnt;
      wait_cyc(t0 + 12);
      check("C go high", go, 1);
      check("C on bus", data_out, 4);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_cyc(t0 + 14);
      check("reset go", go, 0);
      check("reset busy", busy, 0);
      check("reset result", result, 0);
      check("reset done", done, 0);
      check("reset data_out", data_out, 0);
      wait_cyc(t0 + 30);
      check("no done after reset", done_cnt, dc);
      check("ops consumed", exp_ops.size(), 0);

      push_txn(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 8'd3);
      run_start(8'd1, 8'd1, 8'd1, 8'd1, t0);
      wait_done(dc + 1);
      wait_cyc(last_done_cyc + 2);
      check("scoreboard drained", exp_res.size(), 0);
      check("ops drained", exp_ops.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
